transceiver_tx_replay_ctrl: RTL and testbench
=============================================

Name: transceiver_tx_replay_ctrl

Overview:
- Transmit-side TLP holder that carries out the commands issued by the link controller: start, stop, replay and id_ack.
- Buffers one TLP from the upstream source, streams it to the framer tagged with a sequence ID, then raises an ack request and holds the copy until acknowledged.
- On replay it resends the held TLP.
- Stop-and-wait ARQ end of the ACK/NACK DLLP protocol, on the transmitter side of the lvds transceiver.

Parameters:
- TLP_ID_WIDTH, 3: sequence ID width. The ID wraps modulo 2^TLP_ID_WIDTH.
- DATA_WIDTH, 8: width of one TLP word.
- DEPTH, 16: maximum TLP length in words. Must be ≥2.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous reset, active-high
- i_tlp_data  in  DATA_WIDTH  upstream TLP word
- i_tlp_valid  in  1  upstream word valid
- i_tlp_last  in  1  upstream last word of TLP
- o_tlp_ready  out  1  block accepts upstream word
- o_tx_data  out  DATA_WIDTH  word to framer
- o_tx_valid  out  1  framer word valid
- o_tx_last  out  1  last word of TLP to framer
- o_tx_id  out  TLP_ID_WIDTH  sequence ID of TLP being sent
- i_tx_ready  in  1  framer accepts word
- i_tx_start  in  1  pulse: enable transmission
- i_tx_stop  in  1  pulse: disable transmission (receiver not ready)
- i_tx_rply  in  1  pulse: replay held TLP (NACK or timeout)
- i_tx_id_ack  in  1  pulse: held TLP acknowledged
- o_tx_ack_req  out  1  TLP sent, waiting for ACK; drives the controller's timeout counter
- o_tx_ack_id  out  TLP_ID_WIDTH  ID awaiting ACK (= o_tx_id)
- o_rply_cnt  out  8  saturating count of replays executed

Behaviour:
- Reset (async, i_arst=1) forces the following; these are the reset values:
  - state S_IDLE, r_enable=0, r_len=0, r_rd_addr=0, r_tlp_id=0, o_rply_cnt=0.
  - Outputs: o_tx_valid=0, o_tx_last=0, o_tx_ack_req=0, o_tx_id=0, o_tlp_ready=1.
- Reset mid-operation discards the held TLP and restarts the ID at 0.
- Enable flag: i_tx_start sets r_enable and i_tx_stop clears it, both on the next edge. If both are asserted in the same cycle, stop wins.
- One-hot FSM, registered state:
  - S_IDLE:
    - o_tlp_ready=1.
    - An accepted word is written at addr 0 and r_len=1.
    - If i_tlp_last is also set, go to S_READY; otherwise go to S_LOAD.
  - S_LOAD:
    - o_tlp_ready=1.
    - Each accepted word is written at r_len and r_len is incremented.
    - Go to S_READY when i_tlp_last is set, or when the word just written is word DEPTH (forced end of TLP). Any following words belong to the next TLP.
  - S_READY:
    - o_tlp_ready=0, r_rd_addr=0.
    - Go to S_SEND if r_enable; otherwise hold.
  - S_SEND:
    - o_tx_valid=1, o_tx_data=buf[r_rd_addr], o_tx_last=(r_rd_addr==r_len-1), o_tx_id=r_tlp_id.
    - The data is a combinational read of the register array.
    - On i_tx_ready, r_rd_addr is incremented. On i_tx_ready with o_tx_last, go to S_WAIT_ACK.
    - i_tx_stop does not truncate a TLP in flight.
  - S_WAIT_ACK:
    - o_tx_ack_req=1.
    - On i_tx_id_ack: r_tlp_id is incremented (wraps 2^W-1→0) and the block goes to S_IDLE. id_ack has priority over a same-cycle rply.
    - On i_tx_rply: o_rply_cnt is incremented (saturates at 255) and the block goes to S_READY. The replay waits for r_enable.
- i_tx_rply and i_tx_id_ack are ignored in every state except S_WAIT_ACK.
- Latency:
  - Last upload word accepted → first o_tx_valid: 2 cycles when enabled.
  - Replay pulse → o_tx_valid: 2 cycles.
  - id_ack → o_tlp_ready: 1 cycle.
- r_len and r_rd_addr widths are clog2(DEPTH+1). Memory has no reset; only control is reset.

Decomposition:
- Shared package/header holds:
  - the clog2/padding functions;
  - DLLP field constants (bit 15 ack/control type, bit 8 status/nack bit);
  - the default TLP_ID_WIDTH.
- One sub-module: transceiver_replay_ram, a DEPTH x DATA_WIDTH register array with 1 write port and 1 asynchronous read port.
- FSM and counters stay in the top.

Test Plan:
- Reset release, then a 4-word TLP 0x11,0x22,0x33,0x44, then i_tx_start; i_tx_ready=1 → o_tx_valid for 4 cycles with the same data, o_tx_last on 0x44, o_tx_id=0, then o_tx_ack_req=1 and o_tx_ack_id=0.
- In S_WAIT_ACK, pulse i_tx_id_ack → o_tx_ack_req=0 next cycle, o_tlp_ready=1. The next TLP is sent with o_tx_id=1. After 8 acked TLPs the ID wraps to 0.
- In S_WAIT_ACK, pulse i_tx_rply → the identical 4 words are resent with the same ID, o_rply_cnt=1. 300 replays → o_rply_cnt saturates at 255.
- TLP loaded with r_enable=0 → stays in S_READY with o_tx_valid=0. i_tx_stop pulsed mid-send with i_tx_ready toggling 1/0 → the full TLP completes and no word is lost or duplicated.
- Upload of 20 words with no i_tlp_last (DEPTH=16) → the first TLP has 16 words with o_tx_last on word 16. The remaining 4 words form the next TLP after ACK.
- Assert i_arst during S_SEND → outputs return to reset values asynchronously. After release the next TLP uses ID 0. i_tx_id_ack in S_IDLE has no effect.

Source files
------------

// File: rtl/transceiver_tx_replay_ctrl_pkg.sv
// Shared definitions for the transmit-side replay controller: sizing helpers,
// DLLP field positions, the default sequence-ID width and the FSM state type.
package transceiver_tx_replay_ctrl_pkg;

    // Default width of the TLP sequence ID (IDs wrap modulo 2**width).
    localparam int unsigned TLP_ID_WIDTH_DEFAULT = 3;

    // DLLP field positions: bit 15 selects ACK/control type, bit 8 is the NACK status bit.
    localparam int unsigned DLLP_TYPE_BIT = 15;
    localparam int unsigned DLLP_NACK_BIT = 8;

    // Ceiling log2, never smaller than 1 so it is always usable as a vector width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'(1) << res) < 64'(value)) begin
            res = res + 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

    // Round a width up to the next multiple of align.
    function automatic int unsigned pad_width(input int unsigned width, input int unsigned align);
        return ((width + align - 1) / align) * align;
    endfunction

    // One-hot controller states.
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_LOAD     = 5'b00010,
        S_READY    = 5'b00100,
        S_SEND     = 5'b01000,
        S_WAIT_ACK = 5'b10000
    } state_e;

endpackage

// File: rtl/transceiver_replay_ram.sv
// Replay storage: DEPTH x DATA_WIDTH register array, one synchronous write port
// and one asynchronous read port. No reset; contents are only meaningful below r_len.
module transceiver_replay_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/transceiver_tx_replay_ctrl.sv
// Stop-and-wait transmit holder: buffers one TLP, streams it to the framer with
// a sequence ID, then holds it until the link controller acks or asks for a replay.
module transceiver_tx_replay_ctrl
    import transceiver_tx_replay_ctrl_pkg::*;
#(
    parameter int unsigned TLP_ID_WIDTH = TLP_ID_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [DATA_WIDTH-1:0]   i_tlp_data,
    input  logic                    i_tlp_valid,
    input  logic                    i_tlp_last,
    output logic                    o_tlp_ready,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    output logic                    o_tx_last,
    output logic [TLP_ID_WIDTH-1:0] o_tx_id,
    input  logic                    i_tx_ready,
    input  logic                    i_tx_start,
    input  logic                    i_tx_stop,
    input  logic                    i_tx_rply,
    input  logic                    i_tx_id_ack,
    output logic                    o_tx_ack_req,
    output logic [TLP_ID_WIDTH-1:0] o_tx_ack_id,
    output logic [7:0]              o_rply_cnt
);

    localparam int unsigned LW = clog2(DEPTH + 1);
    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [LW-1:0] LEN_LAST_IDX = LW'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [LW-1:0]           r_len;
    logic [LW-1:0]           r_rd_addr;
    logic [TLP_ID_WIDTH-1:0] r_tlp_id;
    logic                    r_enable;
    logic [7:0]              r_rply_cnt;

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    send_last;

    assign send_last = (r_rd_addr == (r_len - LW'(1)));
    assign wr_en     = o_tlp_ready && i_tlp_valid;
    assign wr_addr   = (state_q == S_LOAD) ? r_len[AW-1:0] : '0;

    transceiver_replay_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (i_tlp_data),
        .rd_addr (r_rd_addr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Next-state and decoded outputs.
    always_comb begin
        state_d      = state_q;
        o_tlp_ready  = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_last    = 1'b0;
        o_tx_ack_req = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                o_tlp_ready = 1'b1;
                if (i_tlp_valid) begin
                    state_d = i_tlp_last ? S_READY : S_LOAD;
                end
            end
            S_LOAD: begin
                o_tlp_ready = 1'b1;
                // A word landing in the last slot closes the TLP even without i_tlp_last.
                if (i_tlp_valid && (i_tlp_last || (r_len == LEN_LAST_IDX))) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (r_enable) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_last  = send_last;
                if (i_tx_ready && send_last) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                o_tx_ack_req = 1'b1;
                if (i_tx_id_ack) begin
                    state_d = S_IDLE;
                end else if (i_tx_rply) begin
                    state_d = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transmit enable; stop wins over a same-cycle start.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_enable <= 1'b0;
        end else if (i_tx_stop) begin
            r_enable <= 1'b0;
        end else if (i_tx_start) begin
            r_enable <= 1'b1;
        end
    end

    // Length, read pointer, sequence ID and replay counter.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_len      <= '0;
            r_rd_addr  <= '0;
            r_tlp_id   <= '0;
            r_rply_cnt <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_tlp_valid) begin
                        r_len <= LW'(1);
                    end
                end
                S_LOAD: begin
                    if (i_tlp_valid) begin
                        r_len <= r_len + LW'(1);
                    end
                end
                S_READY: begin
                    r_rd_addr <= '0;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        r_rd_addr <= r_rd_addr + LW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (i_tx_id_ack) begin
                        r_tlp_id <= r_tlp_id + TLP_ID_WIDTH'(1);
                    end else if (i_tx_rply && (r_rply_cnt != 8'hFF)) begin
                        r_rply_cnt <= r_rply_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_tx_data   = rd_data;
    assign o_tx_id     = r_tlp_id;
    assign o_tx_ack_id = r_tlp_id;
    assign o_rply_cnt  = r_rply_cnt;

endmodule

// File: tb/tb_transceiver_tx_replay_ctrl.sv
// Self-checking bench for transceiver_tx_replay_ctrl: random TLPs checked against
// a queue-based model of what the framer should see, plus ID and replay counts.
module tb_transceiver_tx_replay_ctrl;

    localparam int DW    = 8;
    localparam int IDW   = 3;
    localparam int DEPTH = 16;

    logic           i_clk = 1'b0;
    logic           i_arst = 1'b1;
    logic [DW-1:0]  i_tlp_data = '0;
    logic           i_tlp_valid = 1'b0;
    logic           i_tlp_last = 1'b0;
    logic           o_tlp_ready;
    logic [DW-1:0]  o_tx_data;
    logic           o_tx_valid;
    logic           o_tx_last;
    logic [IDW-1:0] o_tx_id;
    logic           i_tx_ready = 1'b0;
    logic           i_tx_start = 1'b0;
    logic           i_tx_stop = 1'b0;
    logic           i_tx_rply = 1'b0;
    logic           i_tx_id_ack = 1'b0;
    logic           o_tx_ack_req;
    logic [IDW-1:0] o_tx_ack_id;
    logic [7:0]     o_rply_cnt;

    int checks = 0;
    int failures = 0;

    // Model state: words of the TLP currently held, expected ID and replay count.
    logic [DW-1:0]  up_q[$];
    logic [DW-1:0]  all_q[$];
    int             exp_id = 0;
    int             exp_rply = 0;

    // Words observed at the framer during the latest capture.
    logic [DW-1:0]  cap_data[$];
    bit             cap_last[$];
    logic [IDW-1:0] cap_id[$];

    transceiver_tx_replay_ctrl #(
        .TLP_ID_WIDTH (IDW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_tlp_data   (i_tlp_data),
        .i_tlp_valid  (i_tlp_valid),
        .i_tlp_last   (i_tlp_last),
        .o_tlp_ready  (o_tlp_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .o_tx_last    (o_tx_last),
        .o_tx_id      (o_tx_id),
        .i_tx_ready   (i_tx_ready),
        .i_tx_start   (i_tx_start),
        .i_tx_stop    (i_tx_stop),
        .i_tx_rply    (i_tx_rply),
        .i_tx_id_ack  (i_tx_id_ack),
        .o_tx_ack_req (o_tx_ack_req),
        .o_tx_ack_id  (o_tx_ack_id),
        .o_rply_cnt   (o_rply_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic fill_random(input int n);
        up_q.delete();
        for (int i = 0; i < n; i++) begin
            up_q.push_back(DW'($urandom_range(0, 255)));
        end
    endtask

    // One-cycle pulse: 0 start, 1 stop, 2 replay, 3 id_ack. Returns at the
    // negedge after the edge that sampled it.
    task automatic pulse(input int which);
        @(negedge i_clk);
        i_tx_start  = (which == 0);
        i_tx_stop   = (which == 1);
        i_tx_rply   = (which == 2);
        i_tx_id_ack = (which == 3);
        @(negedge i_clk);
        i_tx_start  = 1'b0;
        i_tx_stop   = 1'b0;
        i_tx_rply   = 1'b0;
        i_tx_id_ack = 1'b0;
    endtask

    // Push up_q[0..n-1] upstream; returns 1ns after the edge accepting the last word.
    task automatic upload(input int n, input bit with_last, output bit timed_out);
        int w;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            @(negedge i_clk);
            i_tlp_valid = 1'b1;
            i_tlp_data  = up_q[i];
            i_tlp_last  = with_last && (i == n - 1);
            while (!o_tlp_ready && w < 100) begin
                @(negedge i_clk);
                w++;
            end
            if (!o_tlp_ready) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        i_tlp_valid = 1'b0;
        i_tlp_last  = 1'b0;
    endtask

    // Collect one TLP from the framer side; returns at a negedge after its last word.
    task automatic capture(input bit rand_ready, input bit stop_mid, output bit timed_out);
        bit done;
        bit stopped;
        done = 1'b0;
        stopped = 1'b0;
        cap_data.delete();
        cap_last.delete();
        cap_id.delete();
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clk);
            i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_tx_stop  = 1'b0;
            if (stop_mid && !stopped && cap_data.size() >= 2) begin
                i_tx_stop = 1'b1;
                stopped = 1'b1;
            end
            if (o_tx_valid && i_tx_ready) begin
                cap_data.push_back(o_tx_data);
                cap_last.push_back(o_tx_last);
                cap_id.push_back(o_tx_id);
                if (o_tx_last) done = 1'b1;
            end
            if (done) begin
                @(posedge i_clk);
                break;
            end
        end
        @(negedge i_clk);
        i_tx_ready = 1'b0;
        i_tx_stop  = 1'b0;
        timed_out  = !done;
    endtask

    task automatic test_reset();
        i_arst = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", o_tx_valid); end
        checks++; if (o_tx_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", o_tx_last); end
        checks++; if (o_tx_ack_req !== 1'b0) begin failures++; $display("FAIL reset_ack_req: got %b want 0", o_tx_ack_req); end
        checks++; if (o_tx_id !== '0) begin failures++; $display("FAIL reset_id: got %0d want 0", o_tx_id); end
        checks++; if (o_tlp_ready !== 1'b1) begin failures++; $display("FAIL reset_tlp_ready: got %b want 1", o_tlp_ready); end
        checks++; if (o_rply_cnt !== 8'd0) begin failures++; $display("FAIL reset_rply_cnt: got %0d want 0", o_rply_cnt); end
        i_arst = 1'b0;
        exp_id = 0;
        exp_rply = 0;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        bit to;
        pulse(0);
        up_q.delete();
        up_q.push_back(8'h11); up_q.push_back(8'h22); up_q.push_back(8'h33); up_q.push_back(8'h44);
        upload(4, 1'b1, to);
        checks++; if (to) begin failures++; $display("FAIL basic_upload: timeout got 1 want 0"); end
        @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1: valid got %b want 0", o_tx_valid); end
        @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL basic_lat2: valid got %b want 1", o_tx_valid); end
        capture(1'b0, 1'b0, to);
        checks++; if (to || cap_data.size() != 4) begin failures++; $display("FAIL basic_len: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            checks++;
            if (cap_data[i] !== up_q[i] || cap_last[i] !== (i == 3) || cap_id[i] !== IDW'(exp_id)) begin
                failures++;
                $display("FAIL basic_word%0d: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                         i, cap_data[i], cap_last[i], cap_id[i], up_q[i], (i == 3), exp_id);
            end
        end
        checks++; if (o_tx_ack_req !== 1'b1) begin failures++; $display("FAIL basic_ack_req: got %b want 1", o_tx_ack_req); end
        checks++; if (o_tx_ack_id !== IDW'(exp_id)) begin failures++; $display("FAIL basic_ack_id: got %0d want %0d", o_tx_ack_id, exp_id); end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
        checks++; if (o_tx_ack_req !== 1'b0) begin failures++; $display("FAIL basic_ack_clr: got %b want 0", o_tx_ack_req); end
        checks++; if (o_tlp_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_ack: got %b want 1", o_tlp_ready); end
    endtask

    task automatic test_id_wrap();
        bit to;
        int n;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, DEPTH);
            fill_random(n);
            upload(n, 1'b1, to);
            capture(1'b1, 1'b0, to);
            checks++; if (to || cap_data.size() != n) begin failures++; $display("FAIL wrap_len%0d: got %0d want %0d", t, cap_data.size(), n); end
            for (int i = 0; i < cap_data.size() && i < n; i++) begin
                checks++;
                if (cap_data[i] !== up_q[i] || cap_last[i] !== (i == n - 1) || cap_id[i] !== IDW'(exp_id)) begin
                    failures++;
                    $display("FAIL wrap%0d_word%0d: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                             t, i, cap_data[i], cap_last[i], cap_id[i], up_q[i], (i == n - 1), exp_id);
                end
            end
            pulse(3);
            exp_id = (exp_id + 1) % (1 << IDW);
        end
    endtask

    task automatic test_replay();
        bit to;
        int errs;
        fill_random(4);
        upload(4, 1'b1, to);
        capture(1'b0, 1'b0, to);
        checks++; if (to || cap_data.size() != 4) begin failures++; $display("FAIL rply_first_len: got %0d want 4", cap_data.size()); end
        pulse(2);
        exp_rply = (exp_rply < 255) ? exp_rply + 1 : 255;
        checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL rply_lat1: valid got %b want 0", o_tx_valid); end
        @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL rply_lat2: valid got %b want 1", o_tx_valid); end
        capture(1'b1, 1'b0, to);
        checks++; if (to || cap_data.size() != 4) begin failures++; $display("FAIL rply_len: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            checks++;
            if (cap_data[i] !== up_q[i] || cap_last[i] !== (i == 3) || cap_id[i] !== IDW'(exp_id)) begin
                failures++;
                $display("FAIL rply_word%0d: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                         i, cap_data[i], cap_last[i], cap_id[i], up_q[i], (i == 3), exp_id);
            end
        end
        checks++; if (o_rply_cnt !== 8'(exp_rply)) begin failures++; $display("FAIL rply_cnt1: got %0d want %0d", o_rply_cnt, exp_rply); end
        errs = 0;
        for (int r = 1; r < 300; r++) begin
            pulse(2);
            exp_rply = (exp_rply < 255) ? exp_rply + 1 : 255;
            capture(1'b0, 1'b0, to);
            if (to || cap_data.size() != 4 || cap_data[0] !== up_q[0] || cap_data[3] !== up_q[3]) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL rply_loop: bad resends got %0d want 0", errs); end
        checks++; if (o_rply_cnt !== 8'(exp_rply)) begin failures++; $display("FAIL rply_sat: got %0d want %0d", o_rply_cnt, exp_rply); end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
    endtask

    task automatic test_disabled_stop();
        bit to;
        int n;
        pulse(1);
        n = $urandom_range(5, 12);
        fill_random(n);
        upload(n, 1'b1, to);
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            checks++; if (o_tx_valid !== 1'b0) begin failures++; $display("FAIL dis_hold%0d: valid got %b want 0", c, o_tx_valid); end
        end
        // Replay and ack outside the ack-wait state must be ignored.
        pulse(2);
        pulse(3);
        checks++; if (o_rply_cnt !== 8'(exp_rply)) begin failures++; $display("FAIL dis_rply_ign: got %0d want %0d", o_rply_cnt, exp_rply); end
        checks++; if (o_tx_valid !== 1'b0 || o_tlp_ready !== 1'b0) begin failures++; $display("FAIL dis_state: valid=%b ready=%b want 0 0", o_tx_valid, o_tlp_ready); end
        pulse(0);
        capture(1'b1, 1'b1, to);
        checks++; if (to || cap_data.size() != n) begin failures++; $display("FAIL stop_len: got %0d want %0d", cap_data.size(), n); end
        for (int i = 0; i < cap_data.size() && i < n; i++) begin
            checks++;
            if (cap_data[i] !== up_q[i] || cap_last[i] !== (i == n - 1) || cap_id[i] !== IDW'(exp_id)) begin
                failures++;
                $display("FAIL stop_word%0d: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                         i, cap_data[i], cap_last[i], cap_id[i], up_q[i], (i == n - 1), exp_id);
            end
        end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
        pulse(0);
    endtask

    task automatic test_overflow();
        bit to;
        all_q.delete();
        for (int i = 0; i < 20; i++) all_q.push_back(DW'($urandom_range(0, 255)));
        up_q.delete();
        for (int i = 0; i < DEPTH; i++) up_q.push_back(all_q[i]);
        upload(DEPTH, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL ovf_upload: timeout got 1 want 0"); end
        checks++; if (o_tlp_ready !== 1'b0) begin failures++; $display("FAIL ovf_forced_end: ready got %b want 0", o_tlp_ready); end
        capture(1'b0, 1'b0, to);
        checks++; if (to || cap_data.size() != DEPTH) begin failures++; $display("FAIL ovf_len: got %0d want %0d", cap_data.size(), DEPTH); end
        for (int i = 0; i < cap_data.size() && i < DEPTH; i++) begin
            checks++;
            if (cap_data[i] !== all_q[i] || cap_last[i] !== (i == DEPTH - 1)) begin
                failures++;
                $display("FAIL ovf_word%0d: got d=%h l=%b want d=%h l=%b",
                         i, cap_data[i], cap_last[i], all_q[i], (i == DEPTH - 1));
            end
        end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
        up_q.delete();
        for (int i = DEPTH; i < 20; i++) up_q.push_back(all_q[i]);
        upload(4, 1'b1, to);
        capture(1'b1, 1'b0, to);
        checks++; if (to || cap_data.size() != 4) begin failures++; $display("FAIL ovf_tail_len: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            checks++;
            if (cap_data[i] !== all_q[DEPTH + i] || cap_last[i] !== (i == 3) || cap_id[i] !== IDW'(exp_id)) begin
                failures++;
                $display("FAIL ovf_tail%0d: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                         i, cap_data[i], cap_last[i], cap_id[i], all_q[DEPTH + i], (i == 3), exp_id);
            end
        end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
    endtask

    task automatic test_reset_mid();
        bit to;
        fill_random(8);
        upload(8, 1'b1, to);
        repeat (2) @(negedge i_clk);
        i_tx_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++; if (o_tx_valid !== 1'b1) begin failures++; $display("FAIL mid_in_send: valid got %b want 1", o_tx_valid); end
        #2;
        i_arst = 1'b1;
        #1;
        checks++; if (o_tx_valid !== 1'b0 || o_tx_last !== 1'b0) begin failures++; $display("FAIL mid_async_valid: valid=%b last=%b want 0 0", o_tx_valid, o_tx_last); end
        checks++; if (o_tlp_ready !== 1'b1 || o_tx_ack_req !== 1'b0) begin failures++; $display("FAIL mid_async_ctl: ready=%b ack_req=%b want 1 0", o_tlp_ready, o_tx_ack_req); end
        checks++; if (o_tx_id !== '0 || o_rply_cnt !== 8'd0) begin failures++; $display("FAIL mid_async_cnt: id=%0d rply=%0d want 0 0", o_tx_id, o_rply_cnt); end
        i_tx_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_arst = 1'b0;
        exp_id = 0;
        exp_rply = 0;
        pulse(3);
        pulse(0);
        fill_random(3);
        upload(3, 1'b1, to);
        capture(1'b0, 1'b0, to);
        checks++; if (to || cap_data.size() != 3) begin failures++; $display("FAIL post_rst_len: got %0d want 3", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 3; i++) begin
            checks++;
            if (cap_data[i] !== up_q[i] || cap_id[i] !== IDW'(exp_id)) begin
                failures++;
                $display("FAIL post_rst_word%0d: got d=%h id=%0d want d=%h id=%0d",
                         i, cap_data[i], cap_id[i], up_q[i], exp_id);
            end
        end
        checks++; if (o_tx_ack_id !== IDW'(exp_id)) begin failures++; $display("FAIL post_rst_ack_id: got %0d want %0d", o_tx_ack_id, exp_id); end
        pulse(3);
        exp_id = (exp_id + 1) % (1 << IDW);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_id_wrap();
        test_replay();
        test_disabled_stop();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
